// File: rtl/wokwi_395054823837887489_tile_pkg.sv
// Shared constants for the 4-mode state engine: mode encodings, LFSR taps and seed.
package wokwi_395054823837887489_tile_pkg;

  localparam int          WIDTH_DEF     = 8;
  localparam logic [1:0]  MODE_COUNT    = 2'b00;
  localparam logic [1:0]  MODE_LFSR     = 2'b01;
  localparam logic [1:0]  MODE_SHIFT    = 2'b10;
  localparam logic [1:0]  MODE_LOAD     = 2'b11;
  // Taps r[7], r[5], r[4], r[3]: x^8+x^6+x^5+x^4+1, maximal length (255).
  localparam logic [7:0]  LFSR_TAP_MASK = 8'hB8;
  localparam logic [7:0]  LFSR_SEED_DEF = 8'h01;

  function automatic logic lfsr_feedback(input logic [7:0] r);
    return ^(r & LFSR_TAP_MASK);
  endfunction

endpackage

// File: rtl/wokwi_395054823837887489_tile_next_state.sv
// Purely combinational next-state selection over the four engine modes.
module wokwi_395054823837887489_tile_next_state
  import wokwi_395054823837887489_tile_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic [7:0] r_q,
  input  logic [7:0] ui_in,
  output logic [7:0] r_d
);

  logic [1:0] mode;
  logic       step;

  assign mode = ui_in[7:6];
  assign step = ui_in[0];

  always_comb begin
    r_d = r_q;
    case (mode)
      MODE_COUNT: begin
        if (step) r_d = ui_in[1] ? r_q - 8'd1 : r_q + 8'd1;
      end
      MODE_LFSR: begin
        // The all-zero state is a lock-up point for an XOR LFSR, so reseed it.
        if (step) r_d = (r_q == 8'h00) ? LFSR_SEED : {r_q[6:0], lfsr_feedback(r_q)};
      end
      MODE_SHIFT: begin
        if (step) r_d = {r_q[6:0], ui_in[2]};
      end
      default: begin
        r_d = {2'b00, ui_in[5:0]};
      end
    endcase
  end

endmodule

// File: rtl/wokwi_395054823837887489_tile.sv
// Tile top: single 8-bit state register with asynchronous reset, driven by the
// next-state engine; the register drives uo_out directly.
module wokwi_395054823837887489_tile
  import wokwi_395054823837887489_tile_pkg::*;
#(
  parameter int         WIDTH     = WIDTH_DEF,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ui_in,
  output logic [WIDTH-1:0] uo_out
);

  logic [7:0] r_q;
  logic [7:0] r_d;

  wokwi_395054823837887489_tile_next_state #(
    .LFSR_SEED(LFSR_SEED)
  ) u_next_state (
    .r_q  (r_q),
    .ui_in(ui_in),
    .r_d  (r_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 8'h00;
    else     r_q <= r_d;
  end

  assign uo_out = r_q;

endmodule

// File: tb/tb_wokwi_395054823837887489_tile.sv
// Self-checking bench for the tile: directed scenarios plus random mode/ui_in
// traffic compared against an arithmetic reference model.
module tb_wokwi_395054823837887489_tile;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] model_r;

  wokwi_395054823837887489_tile dut (
    .clk   (clk),
    .rst   (rst),
    .ui_in (ui_in),
    .uo_out(uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each mode's rule expressed as plain integer arithmetic.
  function automatic logic [7:0] model_next(input logic [7:0] r, input logic [7:0] ui);
    int v;
    int fb;
    v = r;
    case (ui[7:6])
      2'b00: if (ui[0]) v = ui[1] ? (v + 255) % 256 : (v + 1) % 256;
      2'b01: if (ui[0]) begin
        if (v == 0) v = 1;
        else begin
          fb = ((v >> 7) & 1) ^ ((v >> 5) & 1) ^ ((v >> 4) & 1) ^ ((v >> 3) & 1);
          v  = (v * 2 + fb) % 256;
        end
      end
      2'b10: if (ui[0]) v = (v * 2 + int'(ui[2])) % 256;
      default: v = ui % 64;
    endcase
    return v[7:0];
  endfunction

  task automatic step(input logic [7:0] ui);
    ui_in = ui;
    @(posedge clk);
    #1;
    model_r = rst ? 8'h00 : model_next(model_r, ui);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_r = 8'h00;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (uo_out !== 8'h00) $display("FAIL reset_init: got %h want 00", uo_out);
    else pass_cnt++;
    rst = 1'b0;
    step({2'b11, 6'h37});
    total_cnt++;
    if (uo_out !== 8'h37) $display("FAIL reset_preload: got %h want 37", uo_out);
    else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (uo_out !== 8'h00) $display("FAIL reset_async: got %h want 00", uo_out);
    else pass_cnt++;
    ui_in = {2'b00, 6'h01};
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (uo_out !== 8'h00) $display("FAIL reset_held: got %h want 00", uo_out);
    else pass_cnt++;
    rst = 1'b0;
    model_r = 8'h00;
    $display("test_reset done");
  endtask

  task automatic test_count();
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      step({2'b00, 3'($urandom), 1'b0, 1'b0, 1'b1});
      exp = 8'(i % 256);
      total_cnt++;
      if (uo_out !== exp || uo_out !== model_r)
        $display("FAIL count_up[%0d]: got %h want %h", i, uo_out, exp);
      else pass_cnt++;
    end
    step({2'b00, 3'($urandom), 1'b0, 1'b1, 1'b1});
    total_cnt++;
    if (uo_out !== 8'hFF) $display("FAIL count_down_wrap: got %h want FF", uo_out);
    else pass_cnt++;
    $display("test_count done");
  endtask

  task automatic test_lfsr();
    logic [7:0] first [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step({2'b01, 3'($urandom), 2'($urandom), 1'b1});
      total_cnt++;
      if (uo_out !== first[i]) $display("FAIL lfsr_seq[%0d]: got %h want %h", i, uo_out, first[i]);
      else pass_cnt++;
    end
    // 4 steps already taken past 01; 251 more completes the 255-cycle period.
    for (int i = 0; i < 251; i++) begin
      step({2'b01, 3'($urandom), 2'($urandom), 1'b1});
      total_cnt++;
      if (uo_out !== model_r || uo_out == 8'h00)
        $display("FAIL lfsr_run[%0d]: got %h want %h", i, uo_out, model_r);
      else pass_cnt++;
    end
    total_cnt++;
    if (uo_out !== 8'h01) $display("FAIL lfsr_period: got %h want 01", uo_out);
    else pass_cnt++;
    $display("test_lfsr done");
  endtask

  task automatic test_shift();
    logic       bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp  [4] = '{8'h01, 8'h02, 8'h05, 8'h0B};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step({2'b10, 3'($urandom), bits[i], 1'($urandom), 1'b1});
      total_cnt++;
      if (uo_out !== exp[i]) $display("FAIL shift[%0d]: got %h want %h", i, uo_out, exp[i]);
      else pass_cnt++;
    end
    step({2'b10, 3'($urandom), 1'b1, 1'($urandom), 1'b0});
    total_cnt++;
    if (uo_out !== 8'h0B) $display("FAIL shift_hold: got %h want 0B", uo_out);
    else pass_cnt++;
    $display("test_shift done");
  endtask

  task automatic test_load_hold();
    step({2'b11, 6'h2A});
    total_cnt++;
    if (uo_out !== 8'h2A) $display("FAIL load: got %h want 2A", uo_out);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step({2'b00, 3'($urandom), 2'($urandom), 1'b0});
      total_cnt++;
      if (uo_out !== 8'h2A) $display("FAIL load_hold[%0d]: got %h want 2A", i, uo_out);
      else pass_cnt++;
    end
    $display("test_load_hold done");
  endtask

  task automatic test_mode_switch();
    do_reset();
    step({2'b00, 6'h00});
    step({2'b01, 6'h01});
    total_cnt++;
    if (uo_out !== 8'h01) $display("FAIL switch_seed: got %h want 01", uo_out);
    else pass_cnt++;
    step({2'b01, 6'h01});
    step({2'b01, 6'h01});
    total_cnt++;
    if (uo_out !== 8'h04) $display("FAIL switch_lfsr: got %h want 04", uo_out);
    else pass_cnt++;
    step({2'b00, 6'h03});
    total_cnt++;
    if (uo_out !== 8'h03) $display("FAIL switch_count_down: got %h want 03", uo_out);
    else pass_cnt++;
    $display("test_mode_switch done");
  endtask

  task automatic test_random();
    logic [7:0] ui;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end
      ui = 8'($urandom);
      step(ui);
      total_cnt++;
      if (uo_out !== model_r) $display("FAIL random[%0d] ui=%h: got %h want %h", i, ui, uo_out, model_r);
      else pass_cnt++;
    end
    $display("test_random done");
  endtask

  initial begin
    rst     = 1'b1;
    ui_in   = 8'h00;
    model_r = 8'h00;
    #12;
    test_reset();
    test_count();
    test_lfsr();
    test_shift();
    test_load_hold();
    test_mode_switch();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
